// File: rtl/detection_result_queue_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkg_detectionQueue: shared types and defaults for the detection result queue
// Revision: 1.0
// ---------------------------------------------------------------------------
package pkg_detectionQueue;

  localparam int DEFAULT_DEPTH      = 16;
  localparam int DEFAULT_COUNT_BITS = 32;
  localparam int DEFAULT_ROW_BITS   = 10;
  localparam int DEFAULT_COL_BITS   = 10;
  localparam int DEFAULT_SCALE_BITS = 4;

  typedef struct packed {
    logic [DEFAULT_SCALE_BITS-1:0] scale;
    logic [DEFAULT_COL_BITS-1:0]   y;
    logic [DEFAULT_ROW_BITS-1:0]   x;
  } detection_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } ackState_t;

endpackage
`default_nettype wire

// File: rtl/detection_result_queue_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// detection_fifo: first-word-fall-through synchronous FIFO with occupancy
// Revision: 1.0
// ---------------------------------------------------------------------------
module detection_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot in the same cycle, so a full FIFO may still take a push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level     = wr_ptr - rd_ptr;
  assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/detection_result_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// detection_result_queue: acknowledges cascade results, keeps statistics and
// queues passing windows for the host. Revision: 1.0
// ---------------------------------------------------------------------------
module detection_result_queue
  import pkg_detectionQueue::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int ROW_BITS     = DEFAULT_ROW_BITS,
  parameter int COL_BITS     = DEFAULT_COL_BITS,
  parameter int SCALE_BITS   = DEFAULT_SCALE_BITS,
  parameter int COUNT_BITS   = DEFAULT_COUNT_BITS,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 res_valid,
  input  logic                                 res_passfail,
  input  logic [ROW_BITS-1:0]                  res_x,
  input  logic [COL_BITS-1:0]                  res_y,
  input  logic [SCALE_BITS-1:0]                res_scale,
  output logic                                 res_taken,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [SCALE_BITS+COL_BITS+ROW_BITS-1:0] out_data,
  input  logic                                 clear_stats,
  output logic [COUNT_BITS-1:0]                cnt_windows,
  output logic [COUNT_BITS-1:0]                cnt_detect,
  output logic [COUNT_BITS-1:0]                cnt_dropped,
  output logic [$clog2(DEPTH):0]               fifo_level
);

  localparam int DATA_W = SCALE_BITS + COL_BITS + ROW_BITS;
  localparam logic [COUNT_BITS-1:0] CNT_ONE = {{(COUNT_BITS-1){1'b0}}, 1'b1};

  ackState_t state;
  ackState_t next_state;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic room;
  logic accept;
  logic push;
  logic drop;

  assign pop    = out_valid & out_ready;
  assign room   = ~fifo_full | pop;
  assign accept = (state == IDLE) & res_valid & (~res_passfail | room | DROP_ON_FULL);
  assign push   = accept & res_passfail & room;
  assign drop   = accept & res_passfail & ~room;

  detection_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({res_scale, res_y, res_x}),
    .pop       (pop),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign out_valid = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // WAIT blocks re-acknowledging a result the processor has not yet withdrawn.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ACK;
      ACK:     next_state = WAIT;
      WAIT:    if (!res_valid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    res_taken = (state == ACK);
  end

  // Saturating statistics; clear_stats overrides a coincident increment.
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      cnt_windows <= '0;
      cnt_detect  <= '0;
      cnt_dropped <= '0;
    end else begin
      if (accept && (cnt_windows != '1)) cnt_windows <= cnt_windows + CNT_ONE;
      if (push   && (cnt_detect  != '1)) cnt_detect  <= cnt_detect  + CNT_ONE;
      if (drop   && (cnt_dropped != '1)) cnt_dropped <= cnt_dropped + CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_detection_result_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_detection_result_queue: directed bench, stall instance and drop instance
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_detection_result_queue;
  import pkg_detectionQueue::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        res_valid = 1'b0;
  logic        res_passfail = 1'b0;
  logic [9:0]  res_x = '0;
  logic [9:0]  res_y = '0;
  logic [3:0]  res_scale = '0;
  logic        out_ready = 1'b0;
  logic        clear_stats = 1'b0;
  logic        en0 = 1'b0;
  logic        en1 = 1'b0;
  logic        mon_en = 1'b0;

  logic        taken0, ov0, taken1, ov1;
  logic [23:0] od0, od1;
  logic [31:0] cw0, cd0, cp0;
  logic [2:0]  cw1, cd1, cp1;
  logic [2:0]  lvl0, lvl1;

  int checks = 0;
  int errors = 0;
  logic [23:0] popped [$];

  always #5 clk = ~clk;

  detection_result_queue #(
    .DEPTH(4), .ROW_BITS(10), .COL_BITS(10), .SCALE_BITS(4),
    .COUNT_BITS(32), .DROP_ON_FULL(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .res_valid(res_valid & en0), .res_passfail(res_passfail),
    .res_x(res_x), .res_y(res_y), .res_scale(res_scale), .res_taken(taken0),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .clear_stats(clear_stats),
    .cnt_windows(cw0), .cnt_detect(cd0), .cnt_dropped(cp0), .fifo_level(lvl0)
  );

  detection_result_queue #(
    .DEPTH(4), .ROW_BITS(10), .COL_BITS(10), .SCALE_BITS(4),
    .COUNT_BITS(3), .DROP_ON_FULL(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .res_valid(res_valid & en1), .res_passfail(res_passfail),
    .res_x(res_x), .res_y(res_y), .res_scale(res_scale), .res_taken(taken1),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .clear_stats(clear_stats),
    .cnt_windows(cw1), .cnt_detect(cd1), .cnt_dropped(cp1), .fifo_level(lvl1)
  );

  always @(negedge clk) begin
    if (mon_en && en0 && ov0 && out_ready) popped.push_back(od0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    res_valid = 1'b0;
    out_ready = 1'b0;
    clear_stats = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Presents one result, waits for the selected instance's acknowledge, then withdraws it.
  task automatic send(input logic pass, input int x, input int y, input int s,
                      input int sel, output int lat);
    res_passfail = pass;
    res_x = x[9:0];
    res_y = y[9:0];
    res_scale = s[3:0];
    res_valid = 1'b1;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      tick;
      if ((sel == 0) ? taken0 : taken1) begin
        lat = i;
        break;
      end
    end
    res_valid = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset;
    en0 = 1'b1; en1 = 1'b1;
    do_reset;
    checks++; if (taken0 !== 1'b0) begin errors++; $display("FAIL rst_taken: got %b expected 0", taken0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", ov0); end
    checks++; if (od0 !== 24'd0) begin errors++; $display("FAIL rst_out_data: got %h expected 0", od0); end
    checks++; if (lvl0 !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", lvl0); end
    checks++; if ({cw0, cd0, cp0} !== 96'd0) begin errors++; $display("FAIL rst_counters: got %0d/%0d/%0d expected 0/0/0", cw0, cd0, cp0); end
    checks++; if ({cw1, cd1, cp1, lvl1, ov1, taken1} !== 14'd0) begin errors++; $display("FAIL rst_dut1: got %0d/%0d/%0d lvl %0d expected zeros", cw1, cd1, cp1, lvl1); end
  endtask

  task automatic test_fail_result;
    en0 = 1'b1; en1 = 1'b0;
    do_reset;
    res_passfail = 1'b0; res_x = 10'd5; res_y = 10'd7; res_scale = 4'd0;
    res_valid = 1'b1;
    tick;
    checks++; if (taken0 !== 1'b1) begin errors++; $display("FAIL fail_taken_lat: got %b expected 1", taken0); end
    tick;
    checks++; if (taken0 !== 1'b0) begin errors++; $display("FAIL fail_taken_width: got %b expected 0", taken0); end
    res_valid = 1'b0;
    tick;
    tick;
    checks++; if (cw0 !== 32'd1) begin errors++; $display("FAIL fail_cnt_windows: got %0d expected 1", cw0); end
    checks++; if (cd0 !== 32'd0) begin errors++; $display("FAIL fail_cnt_detect: got %0d expected 0", cd0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL fail_out_valid: got %b expected 0", ov0); end
  endtask

  task automatic test_pass_result;
    detection_t e;
    e.scale = 4'd2; e.y = 10'd9; e.x = 10'd3;
    en0 = 1'b1; en1 = 1'b0;
    do_reset;
    res_passfail = 1'b1; res_x = 10'd3; res_y = 10'd9; res_scale = 4'd2;
    res_valid = 1'b1;
    tick;
    checks++; if (taken0 !== 1'b1) begin errors++; $display("FAIL pass_taken_lat: got %b expected 1", taken0); end
    checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL pass_out_valid: got %b expected 1", ov0); end
    checks++; if (od0 !== e) begin errors++; $display("FAIL pass_out_data: got %h expected %h", od0, e); end
    res_valid = 1'b0;
    repeat (3) tick;
    checks++; if (ov0 !== 1'b1 || od0 !== e) begin errors++; $display("FAIL pass_hold: got valid %b data %h expected 1 %h", ov0, od0, e); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++; if (ov0 !== 1'b0 || lvl0 !== 3'd0) begin errors++; $display("FAIL pass_drain: got valid %b level %0d expected 0 0", ov0, lvl0); end
    checks++; if (cd0 !== 32'd1) begin errors++; $display("FAIL pass_cnt_detect: got %0d expected 1", cd0); end
  endtask

  task automatic test_stall_full;
    int lat;
    int seen;
    en0 = 1'b1; en1 = 1'b0;
    do_reset;
    for (int i = 1; i <= 4; i++) begin
      send(1'b1, i, 0, 0, 0, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL stall_fill_lat%0d: got %0d expected 1", i, lat); end
    end
    res_passfail = 1'b1; res_x = 10'd5; res_valid = 1'b1;
    seen = 0;
    repeat (5) begin
      tick;
      if (taken0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL stall_no_taken: got %0d pulses expected 0", seen); end
    checks++; if (lvl0 !== 3'd4) begin errors++; $display("FAIL stall_level: got %0d expected 4", lvl0); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++; if (taken0 !== 1'b1) begin errors++; $display("FAIL stall_release_taken: got %b expected 1", taken0); end
    checks++; if (lvl0 !== 3'd4) begin errors++; $display("FAIL stall_release_level: got %0d expected 4", lvl0); end
    checks++; if (od0[9:0] !== 10'd2) begin errors++; $display("FAIL stall_head: got x=%0d expected 2", od0[9:0]); end
    res_valid = 1'b0;
    tick;
    tick;
    checks++; if (cd0 !== 32'd5 || cw0 !== 32'd5) begin errors++; $display("FAIL stall_counts: got %0d/%0d expected 5/5", cw0, cd0); end
  endtask

  task automatic test_drop_full;
    int lat;
    en0 = 1'b0; en1 = 1'b1;
    do_reset;
    for (int i = 1; i <= 4; i++) begin
      send(1'b1, i, 0, 0, 1, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL drop_fill_lat%0d: got %0d expected 1", i, lat); end
    end
    send(1'b1, 9, 0, 0, 1, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL drop_taken_lat: got %0d expected 1", lat); end
    checks++; if (cp1 !== 3'd1) begin errors++; $display("FAIL drop_cnt_dropped: got %0d expected 1", cp1); end
    checks++; if (cd1 !== 3'd4) begin errors++; $display("FAIL drop_cnt_detect: got %0d expected 4", cd1); end
    checks++; if (lvl1 !== 3'd4 || od1[9:0] !== 10'd1) begin errors++; $display("FAIL drop_queue: got level %0d x=%0d expected 4 1", lvl1, od1[9:0]); end
    for (int i = 0; i < 8; i++) send(1'b1, 9, 0, 0, 1, lat);
    checks++; if (cp1 !== 3'd7) begin errors++; $display("FAIL drop_sat_dropped: got %0d expected 7", cp1); end
    checks++; if (cw1 !== 3'd7) begin errors++; $display("FAIL drop_sat_windows: got %0d expected 7", cw1); end
    checks++; if (cd1 !== 3'd4) begin errors++; $display("FAIL drop_sat_detect: got %0d expected 4", cd1); end
  endtask

  task automatic test_wrap_order;
    int lat;
    int waited;
    logic [23:0] exp_word;
    en0 = 1'b1; en1 = 1'b0;
    do_reset;
    popped.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b1, i, 20, 1, 0, lat);
    checks++; if (lvl0 !== 3'd4) begin errors++; $display("FAIL wrap_full_level: got %0d expected 4", lvl0); end
    out_ready = 1'b1;
    res_passfail = 1'b1; res_x = 10'd4; res_y = 10'd20; res_scale = 4'd1;
    res_valid = 1'b1;
    tick;
    checks++; if (taken0 !== 1'b1 || lvl0 !== 3'd4) begin errors++; $display("FAIL wrap_push_pop_full: got taken %b level %0d expected 1 4", taken0, lvl0); end
    res_valid = 1'b0;
    tick;
    tick;
    for (int i = 5; i < 11; i++) send(1'b1, i, 20, 1, 0, lat);
    waited = 0;
    while ((ov0 || lvl0 != 3'd0) && waited < 40) begin
      tick;
      waited++;
    end
    out_ready = 1'b0;
    mon_en = 1'b0;
    checks++; if (popped.size() !== 11) begin errors++; $display("FAIL wrap_count: got %0d entries expected 11", popped.size()); end
    for (int i = 0; i < 11; i++) begin
      exp_word = {4'd1, 10'd20, 10'(i)};
      checks++;
      if (i >= popped.size()) begin
        errors++; $display("FAIL wrap_order%0d: got nothing expected %h", i, exp_word);
      end else if (popped[i] !== exp_word) begin
        errors++; $display("FAIL wrap_order%0d: got %h expected %h", i, popped[i], exp_word);
      end
    end
  endtask

  task automatic test_clear_and_reset;
    int lat;
    en0 = 1'b1; en1 = 1'b0;
    do_reset;
    send(1'b0, 1, 1, 0, 0, lat);
    checks++; if (cw0 !== 32'd1) begin errors++; $display("FAIL clr_pre_windows: got %0d expected 1", cw0); end
    res_passfail = 1'b1; res_x = 10'd6; res_y = 10'd6; res_scale = 4'd3;
    res_valid = 1'b1;
    clear_stats = 1'b1;
    tick;
    clear_stats = 1'b0;
    checks++; if (taken0 !== 1'b1) begin errors++; $display("FAIL clr_taken: got %b expected 1", taken0); end
    checks++; if (cw0 !== 32'd0 || cd0 !== 32'd0) begin errors++; $display("FAIL clr_wins: got %0d/%0d expected 0/0", cw0, cd0); end
    checks++; if (ov0 !== 1'b1 || lvl0 !== 3'd1) begin errors++; $display("FAIL clr_fifo_kept: got valid %b level %0d expected 1 1", ov0, lvl0); end
    res_valid = 1'b0;
    tick;
    tick;
    send(1'b1, 7, 7, 3, 0, lat);
    res_x = 10'd8; res_valid = 1'b1;
    tick;
    checks++; if (taken0 !== 1'b1 || lvl0 !== 3'd3) begin errors++; $display("FAIL rst_mid_setup: got taken %b level %0d expected 1 3", taken0, lvl0); end
    reset = 1'b1;
    tick;
    checks++; if ({taken0, ov0, lvl0} !== 5'd0 || od0 !== 24'd0) begin errors++; $display("FAIL rst_mid_outputs: got taken %b valid %b level %0d data %h expected zeros", taken0, ov0, lvl0, od0); end
    checks++; if ({cw0, cd0, cp0} !== 96'd0) begin errors++; $display("FAIL rst_mid_counters: got %0d/%0d/%0d expected 0/0/0", cw0, cd0, cp0); end
    reset = 1'b0;
    tick;
    checks++; if (taken0 !== 1'b1 || cw0 !== 32'd1 || lvl0 !== 3'd1) begin errors++; $display("FAIL rst_reack: got taken %b windows %0d level %0d expected 1 1 1", taken0, cw0, lvl0); end
    res_valid = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    test_reset;
    test_fail_result;
    test_pass_result;
    test_stall_full;
    test_drop_full;
    test_wrap_order;
    test_clear_and_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
